// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch unit with req/ack memory port, 2-entry queue and redirect handling
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [5:0]  op_o,
   output logic [31:0] instr_pc_o,
   output logic [31:0] pcplus4_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        misalign_o
);
   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;
   logic [0:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] addr_q, addr_d;
   logic        out_q, out_d;
   logic        mis_q, mis_d;
   logic        head_q, head_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] pc_q [2];
   logic [31:0] word_q [2];
   logic        accept, push, pop, wr_idx, hold;
   // A pending request keeps its latched address; a fresh one uses fetch_pc.
   // Requests drop combinationally while reset is asserted.
   assign imem_req_o    = !reset_i & (out_q | (count_q != 2'd2));
   assign imem_addr_o   = out_q ? addr_q : fetch_pc_q;
   assign accept        = imem_req_o & imem_ack_i;
   assign hold          = imem_req_o & !imem_ack_i;
   assign instr_valid_o = (count_q != 2'd0) & (state_q == RUN);
   assign pop           = instr_valid_o & instr_ready_i & !redirect_i;
   assign push          = accept & (state_q == RUN) & !redirect_i;
   assign wr_idx        = head_q ^ count_q[0];
   assign instr_o       = word_q[head_q];
   assign op_o          = word_q[head_q][31:26];
   assign instr_pc_o    = pc_q[head_q];
   assign pcplus4_o     = instr_valid_o ? pc_q[head_q] + 32'd4 : 32'd0;
   assign misalign_o    = mis_q;
   // Next-state: redirect flushes and retargets; an unacked request at redirect forces a drain.
   always_comb begin
      fetch_pc_d = redirect_i ? {redirect_pc_i[31:2], 2'b00} : push ? imem_addr_o + 32'd4 : fetch_pc_q;
      addr_d     = hold ? imem_addr_o : addr_q;
      out_d      = hold;
      state_d    = (redirect_i & hold) ? DRAIN : (state_q == DRAIN && accept) ? RUN : state_q;
      count_d    = redirect_i ? 2'd0 : count_q + 2'(push) - 2'(pop);
      head_d     = redirect_i ? 1'b0 : head_q ^ pop;
      mis_d      = mis_q | (redirect_i & (|redirect_pc_i[1:0]));
   end
   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         out_q      <= 1'b0;
         mis_q      <= 1'b0;
         head_q     <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         out_q      <= out_d;
         mis_q      <= mis_d;
         head_q     <= head_d;
         count_q    <= count_d;
      end
   end
   // Queue storage; a push always finds a free slot because requests start only with room.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q[0]   <= 32'd0;
         pc_q[1]   <= 32'd0;
         word_q[0] <= 32'd0;
         word_q[1] <= 32'd0;
      end else if (push) begin
         pc_q[wr_idx]   <= imem_addr_o;
         word_q[wr_idx] <= imem_rdata_i;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed checks of instr_fetch against a queue-based model
module tb_instr_fetch;
   localparam logic [31:0] RPC = 32'h00400000;
   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ack, instr_valid, instr_ready, redirect, misalign;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pcplus4, redirect_pc;
   logic [5:0]  op;
   int          checks = 0, errors = 0;
   logic [31:0] mq [$];
   logic [31:0] mpc = RPC, paddr = RPC, prev_addr = 0;
   bit          pend = 0, drain = 0, mis = 0, prev_hold = 0, watch = 0;
   bit          e_req, e_valid;
   logic [31:0] e_addr, e_pc;

   instr_fetch #(.RESET_PC(RPC)) dut (
      .clk_i(clk), .reset_i(reset), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata), .instr_valid_o(instr_valid),
      .instr_ready_i(instr_ready), .instr_o(instr), .op_o(op), .instr_pc_o(instr_pc),
      .pcplus4_o(pcplus4), .redirect_i(redirect), .redirect_pc_i(redirect_pc), .misalign_o(misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[7:2] ^ 6'h23, a[27:2]};
   endfunction
   assign imem_rdata = memf(imem_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: fetch stream as a queue of PCs, the word being a pure function of the PC.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         mpc = RPC; paddr = RPC; pend = 0; drain = 0; mis = 0;
      end else begin
         bit r, v;
         logic [31:0] ad;
         r  = pend || mq.size() < 2;
         ad = pend ? paddr : mpc;
         v  = !drain && mq.size() != 0;
         if (v && instr_ready && !redirect) void'(mq.pop_front());
         if (r && imem_ack) begin
            if (drain) drain = 0;
            else if (!redirect) begin
               mq.push_back(ad);
               mpc = ad + 32'd4;
            end
         end
         pend = r && !imem_ack;
         if (pend) paddr = ad;
         if (redirect) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
            if (r && !imem_ack) drain = 1;
            if (redirect_pc[1:0] != 2'b00) mis = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req", 32'(imem_req), 0);
         chk("rst_valid", 32'(instr_valid), 0);
         chk("rst_misalign", 32'(misalign), 0);
         chk("rst_addr", imem_addr, RPC);
         prev_hold = 0;
      end else begin
         e_req   = pend || mq.size() < 2;
         e_addr  = pend ? paddr : mpc;
         e_valid = !drain && mq.size() != 0;
         chk("imem_req", 32'(imem_req), 32'(e_req));
         if (e_req) chk("imem_addr", imem_addr, e_addr);
         chk("instr_valid", 32'(instr_valid), 32'(e_valid));
         chk("misalign", 32'(misalign), 32'(mis));
         if (e_valid) begin
            e_pc = mq[0];
            chk("instr_pc", instr_pc, e_pc);
            chk("instr", instr, memf(e_pc));
            chk("op", 32'(op), 32'(memf(e_pc) >> 26));
            chk("pcplus4", pcplus4, e_pc + 32'd4);
         end
         if (prev_hold) begin
            chk("addr_hold", imem_addr, prev_addr);
            chk("req_hold", 32'(imem_req), 1);
         end
         if (watch) chk("no_stale", 32'(instr_valid && instr_pc == 32'h00400010), 0);
         prev_hold = imem_req && !imem_ack;
         prev_addr = imem_addr;
      end
   end

   initial begin
      int acc;
      reset = 1; imem_ack = 1; instr_ready = 1; redirect = 0; redirect_pc = 0;
      step(); step();
      chk("reset_instr", instr, 0);
      chk("reset_instr_pc", instr_pc, 0);
      chk("reset_pcplus4", pcplus4, 0);
      reset = 0;
      #1;
      chk("first_req", 32'(imem_req), 1);
      chk("first_addr", imem_addr, 32'h00400000);
      step();
      chk("stream_valid0", 32'(instr_valid), 1);
      chk("stream_pc0", instr_pc, 32'h00400000);
      chk("stream_op_lw", 32'(op), 32'h23);
      step();
      chk("stream_pc1", instr_pc, 32'h00400004);
      step();
      chk("stream_pc2", instr_pc, 32'h00400008);
      repeat (4) step();
      // Backpressure from an empty queue.
      redirect = 1; redirect_pc = 32'h00400040; instr_ready = 0;
      step();
      redirect = 0;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         if (imem_req && imem_ack) acc++;
         step();
      end
      chk("bp_accepts", 32'(acc), 2);
      chk("bp_req_low", 32'(imem_req), 0);
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_head", instr_pc, 32'h00400040);
      instr_ready = 1;
      step();
      chk("bp_pop1", instr_pc, 32'h00400044);
      step();
      chk("bp_pop2", instr_pc, 32'h00400048);
      // Wait-state memory.
      for (int i = 0; i < 30; i++) begin
         imem_ack = (i % 3 == 0);
         instr_ready = ($urandom_range(0, 99) < 70);
         step();
      end
      imem_ack = 1; instr_ready = 1;
      step(); step();
      // Redirect with no outstanding request.
      redirect = 1; redirect_pc = 32'h00400100;
      step();
      redirect = 0;
      chk("rd_valid_low", 32'(instr_valid), 0);
      chk("rd_req", 32'(imem_req), 1);
      chk("rd_addr", imem_addr, 32'h00400100);
      step();
      chk("rd_first", instr_pc, 32'h00400100);
      chk("rd_first_valid", 32'(instr_valid), 1);
      // Redirect while a request to 00400010 is outstanding.
      watch = 1;
      redirect = 1; redirect_pc = 32'h00400010;
      step();
      redirect = 0; imem_ack = 0;
      chk("stale_req_addr", imem_addr, 32'h00400010);
      step();
      redirect = 1; redirect_pc = 32'h00400200;
      step();
      redirect = 0;
      chk("drain_valid0", 32'(instr_valid), 0);
      chk("drain_addr0", imem_addr, 32'h00400010);
      step();
      chk("drain_addr1", imem_addr, 32'h00400010);
      imem_ack = 1;
      step();
      chk("post_drain_req", 32'(imem_req), 1);
      chk("post_drain_addr", imem_addr, 32'h00400200);
      repeat (3) step();
      watch = 0;
      // Misaligned redirect target.
      redirect = 1; redirect_pc = 32'h00400102;
      step();
      chk("mis_addr", imem_addr, 32'h00400100);
      chk("mis_set", 32'(misalign), 1);
      redirect_pc = 32'h00400300;
      step();
      redirect = 0;
      chk("mis_sticky", 32'(misalign), 1);
      chk("mis_addr2", imem_addr, 32'h00400300);
      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         imem_ack = ($urandom_range(0, 99) < 60);
         instr_ready = ($urandom_range(0, 99) < 70);
         redirect = ($urandom_range(0, 99) < 6);
         redirect_pc = $urandom;
         if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
         step();
      end
      // Asynchronous reset in the middle of a pending request.
      redirect = 0; imem_ack = 0;
      for (int i = 0; i < 20 && !imem_req; i++) step();
      chk("pre_reset_req", 32'(imem_req), 1);
      @(posedge clk);
      #3;
      reset = 1;
      #1;
      chk("async_req_drop", 32'(imem_req), 0);
      chk("async_valid", 32'(instr_valid), 0);
      chk("async_misalign", 32'(misalign), 0);
      step(); step();
      reset = 0;
      for (int i = 0; i < 150; i++) begin
         imem_ack = ($urandom_range(0, 99) < 75);
         instr_ready = ($urandom_range(0, 99) < 80);
         redirect = ($urandom_range(0, 99) < 5);
         redirect_pc = $urandom & 32'hFFFFFFFC;
         step();
      end
      chk("mis_after_reset", 32'(misalign), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue MIPS core. It sits in front of the main decoder. It drives word addresses to instruction memory over a req/ack handshake and buffers returned words in a 2-entry queue. It presents the head instruction, its PC, and its opcode field to decode with a valid/ready handshake, and it flushes and restarts on branch/jump redirects.

## Interface
- RESET_PC, 32'h00000000, address of the first fetch after reset (bits [1:0] must be 00)
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  word address of the request; bits [1:0] always 00
- imem_ack  input  1  memory accepts the request and returns data in the same cycle
- imem_rdata  input  32  instruction word, sampled only when imem_req & imem_ack
- instr_valid  output  1  queue head is valid
- instr_ready  input  1  decode consumes the head this cycle
- instr  output  32  head instruction word
- op  output  6  instr[31:26], fed to the main decoder
- instr_pc  output  32  PC of the head instruction
- pcplus4  output  32  instr_pc + 4
- redirect  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  32  new fetch target
- misalign  output  1  sticky; set when a redirect_pc has nonzero bits [1:0]

## Operation
- State registers:
  - fetch_pc: next address to request.
  - 2-entry FIFO of {pc, word}, with occupancy count 0..2.
  - outstanding flag: imem_req was raised and not yet acked.
  - FSM with states RUN and DRAIN.
  - misalign flag.
- Request rule in RUN: imem_req = outstanding | (occupancy + pop_this_cycle_excluded < 2).
  - A new request starts only when the queue has a free slot without counting a same-cycle pop.
  - An acked word therefore always has room.
- Once raised, imem_req stays high with imem_addr unchanged until imem_ack. It is never withdrawn, even on redirect.
- imem_ack while imem_req is low is ignored.
- Accept, when imem_req & imem_ack in RUN with no redirect:
  - Push {fetch_pc, imem_rdata}.
  - fetch_pc += 4, wrapping 32'hFFFFFFFC -> 32'h00000000.
  - Clear outstanding.
- Pop: when instr_valid & instr_ready. Push and pop in the same cycle leave occupancy unchanged.
- Redirect when the cycle has no request, or has a request acked in the same cycle:
  - Flush the queue (occupancy 0).
  - Discard any same-cycle acked word.
  - Ignore any same-cycle pop.
  - Set fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Stay in RUN.
- Redirect with a request outstanding and not acked:
  - Flush and load fetch_pc as above.
  - Go to DRAIN.
- DRAIN:
  - imem_req stays high with the stale address.
  - instr_valid is 0.
  - On imem_ack, discard the word and return to RUN.
  - A further redirect in DRAIN overwrites fetch_pc and stays in DRAIN.
- misalign is set on any redirect whose redirect_pc[1:0] != 0. It clears only on reset.
- instr_valid = (occupancy != 0) & (state == RUN).
- instr, op, instr_pc and pcplus4 come from the queue head. They are don't-care when instr_valid is 0.

## Timing
- Reset values, applied asynchronously:
  - imem_req 0, imem_addr RESET_PC, instr_valid 0, misalign 0.
  - occupancy 0, outstanding 0, state RUN.
  - fetch_pc RESET_PC.
  - instr, instr_pc and pcplus4 hold 0.
- First cycle after reset deassert: imem_req 1, imem_addr RESET_PC.
- Latency from ack to valid is 1 cycle: a word acked in cycle t is at the head with instr_valid 1 in cycle t+1.
- Throughput: with zero-wait memory (ack tied high) and ready tied high, one instruction per cycle.
- Redirect in cycle t with no stale request pending: instr_valid is 0 at t+1; imem_req with the new target at t+1; the first new instruction is valid at t+2 with zero-wait memory.
- Redirect with a stale outstanding request acked at cycle a: the new-target request starts at a+1.
- Reset asserted mid-transaction drops imem_req immediately. Memory must tolerate the abandoned request.
- Backpressure: with instr_ready held low, the queue fills to 2 and imem_req then stays low. Outputs hold stable while instr_valid & !instr_ready.

## Test plan
- Reset and stream with RESET_PC=32'h00400000, ack=1, ready=1:
  - The first request is 00400000.
  - instr_pc reads 00400000, 00400004, 00400008 on consecutive cycles.
  - op follows instr[31:26] (e.g. 23 for an lw).
- Backpressure with ready=0 for 5 cycles and ack=1:
  - Exactly 2 words are accepted and imem_req drops.
  - On release the head is unchanged, then 2 pops occur back to back while fetch resumes.
- Wait-state memory with ack every 3rd cycle:
  - imem_addr is stable while req is high.
  - No duplicate or skipped PCs.
- Redirect to 32'h00400100 with no outstanding request:
  - The queue is flushed and valid is 0 next cycle.
  - The next request is 00400100.
- Redirect while a request to 00400010 is outstanding, with ack 2 cycles later:
  - The stale word is discarded.
  - The next request is the redirect target.
  - No instruction from 00400010 is ever valid.
- Redirect to 32'h00400102:
  - Fetch goes to 00400100 and misalign becomes 1.
  - misalign stays 1 through later redirects and clears only on reset.
